// File: rtl/fano_pkg.sv
// Shared definitions for the K=7 convolutional encoder / Fano decoder pair:
// code-rate encoding, puncture period lengths and emit masks, and the
// default generator polynomials.
package fano_pkg;

    typedef enum logic [1:0] {
        RATE_1_2 = 2'd0,
        RATE_2_3 = 2'd1,
        RATE_3_4 = 2'd2,
        RATE_7_8 = 2'd3
    } code_rate_t;

    localparam logic [6:0] G1_DEF = 7'o171;
    localparam logic [6:0] G2_DEF = 7'o133;

    // Emit masks: bit p set means the X (or Y) bit is sent at phase p.
    localparam logic [6:0] PX_1_2 = 7'b0000001;
    localparam logic [6:0] PY_1_2 = 7'b0000001;
    localparam logic [6:0] PX_2_3 = 7'b0000001;
    localparam logic [6:0] PY_2_3 = 7'b0000011;
    localparam logic [6:0] PX_3_4 = 7'b0000101;
    localparam logic [6:0] PY_3_4 = 7'b0000011;
    localparam logic [6:0] PX_7_8 = 7'b1010001;
    localparam logic [6:0] PY_7_8 = 7'b0101111;

    function automatic logic [2:0] period_len(input code_rate_t r);
        case (r)
            RATE_1_2: return 3'd1;
            RATE_2_3: return 3'd2;
            RATE_3_4: return 3'd3;
            default:  return 3'd7;
        endcase
    endfunction

    function automatic logic [6:0] px_mask(input code_rate_t r);
        case (r)
            RATE_1_2: return PX_1_2;
            RATE_2_3: return PX_2_3;
            RATE_3_4: return PX_3_4;
            default:  return PX_7_8;
        endcase
    endfunction

    function automatic logic [6:0] py_mask(input code_rate_t r);
        case (r)
            RATE_1_2: return PY_1_2;
            RATE_2_3: return PY_2_3;
            RATE_3_4: return PY_3_4;
            default:  return PY_7_8;
        endcase
    endfunction

endpackage

// File: rtl/bit_fifo_var.sv
// Shift-register bit FIFO: entry 0 is the oldest bit. Accepts 0..2 bits
// per cycle and releases either none or two. Bits popped in a cycle are
// always the ones that were stored before that cycle's push.
module bit_fifo_var #(
    parameter int BUF_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   push_n,
    input  logic [1:0]                   push_bits,
    input  logic                         pop,
    output logic [1:0]                   head,
    output logic [$clog2(BUF_W+1)-1:0]   count,
    output logic                         room
);

    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam logic [CNT_W-1:0] ROOM_MAX = CNT_W'(BUF_W - 2);

    logic [BUF_W-1:0] mem;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] mem_nxt;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] count_nxt;

    assign head = mem[1:0];

    // Next storage image: drop two on pop, then append new bits after the survivors.
    always_comb begin
        shifted   = pop ? {2'b00, mem[BUF_W-1:2]} : mem;
        base      = count - (pop ? CNT_W'(2) : CNT_W'(0));
        count_nxt = base + CNT_W'(push_n);
        mem_nxt   = shifted;
        for (int i = 0; i < BUF_W; i++) begin
            if ((push_n != 2'd0) && (CNT_W'(i) == base))
                mem_nxt[i] = push_bits[0];
            if ((push_n == 2'd2) && (CNT_W'(i) == base + CNT_W'(1)))
                mem_nxt[i] = push_bits[1];
        end
    end

    // Storage bits carry no reset; count alone defines what is valid.
    always_ff @(posedge clk) begin
        mem <= mem_nxt;
    end

    // Occupancy and the registered "room for two more bits" flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            room  <= 1'b0;
        end else begin
            count <= count_nxt;
            room  <= (count_nxt <= ROOM_MAX);
        end
    end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=7 convolutional encoder with puncturing, optional
// differential precoding and per-rail BPSK (QPSK) mapping. Coded bits are
// buffered and released two at a time, one symbol per request strobe.
module conv_encoder
    import fano_pkg::*;
#(
    parameter int         IQ_WIDTH = 10,
    parameter int         AMP      = 256,
    parameter logic [6:0] G1       = G1_DEF,
    parameter logic [6:0] G2       = G2_DEF,
    parameter int         BUF_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 i_code_rate,
    input  logic                       i_diff_en,
    input  logic                       i_vld,
    input  logic                       i_data,
    output logic                       o_rdy,
    input  logic                       i_sym_req,
    output logic                       o_vld,
    output logic signed [IQ_WIDTH-1:0] o_data_I,
    output logic signed [IQ_WIDTH-1:0] o_data_Q,
    output logic                       o_underflow
);

    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam logic signed [IQ_WIDTH-1:0] AMP_S = IQ_WIDTH'(AMP);

    function automatic logic signed [IQ_WIDTH-1:0] map_bit(input logic b);
        return b ? -AMP_S : AMP_S;
    endfunction

    function automatic logic parity7(input logic [6:0] g, input logic [6:0] v);
        return ^(g & v);
    endfunction

    logic [5:0]       sr;
    logic             d_prev;
    logic [2:0]       phase;
    code_rate_t       rate_q;

    logic             accept_p0;
    logic             d_p0;
    code_rate_t       rate_eff_p0;
    logic [2:0]       len_p0;
    logic [6:0]       mx_p0;
    logic [6:0]       my_p0;
    logic [6:0]       taps_p0;
    logic             x_p0;
    logic             y_p0;
    logic             emit_x_p0;
    logic             emit_y_p0;
    logic [1:0]       push_n_p0;
    logic [1:0]       push_bits_p0;
    logic             pop_p0;
    logic             underflow_p0;
    logic [1:0]       head;
    logic [CNT_W-1:0] count;

    // Stage p0: precode, encode, puncture and decide push/pop for this cycle.
    // The tap vector puts the current bit at position 6 and the bit delayed
    // by k at position 6-k, so sr[0] (newest) lands on tap 5.
    always_comb begin
        accept_p0   = i_vld & o_rdy;
        d_p0        = i_diff_en ? (i_data ^ d_prev) : i_data;
        rate_eff_p0 = (phase == 3'd0) ? code_rate_t'(i_code_rate) : rate_q;
        len_p0      = period_len(rate_eff_p0);
        mx_p0       = px_mask(rate_eff_p0);
        my_p0       = py_mask(rate_eff_p0);
        taps_p0     = '0;
        taps_p0[6]  = d_p0;
        for (int k = 0; k < 6; k++)
            taps_p0[5-k] = sr[k];
        x_p0         = parity7(G1, taps_p0);
        y_p0         = parity7(G2, taps_p0);
        emit_x_p0    = accept_p0 & mx_p0[phase];
        emit_y_p0    = accept_p0 & my_p0[phase];
        push_n_p0    = {1'b0, emit_x_p0} + {1'b0, emit_y_p0};
        push_bits_p0 = emit_x_p0 ? {y_p0, x_p0} : {1'b0, y_p0};
        pop_p0       = i_sym_req & (count >= CNT_W'(2));
        underflow_p0 = i_sym_req & ~pop_p0;
    end

    // Encoder state advances only on an accepted bit; rate latches at phase 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr     <= '0;
            d_prev <= 1'b0;
            phase  <= 3'd0;
            rate_q <= RATE_1_2;
        end else if (accept_p0) begin
            sr     <= {sr[4:0], d_p0};
            d_prev <= d_p0;
            phase  <= (phase == len_p0 - 3'd1) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd0)
                rate_q <= rate_eff_p0;
        end
    end

    bit_fifo_var #(
        .BUF_W(BUF_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_n   (push_n_p0),
        .push_bits(push_bits_p0),
        .pop      (pop_p0),
        .head     (head),
        .count    (count),
        .room     (o_rdy)
    );

    // Stage p1: map popped bit pair to a symbol; samples hold between symbols.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_vld       <= 1'b0;
            o_underflow <= 1'b0;
            o_data_I    <= '0;
            o_data_Q    <= '0;
        end else begin
            o_vld       <= pop_p0;
            o_underflow <= underflow_p0;
            if (pop_p0) begin
                o_data_I <= map_bit(head[0]);
                o_data_Q <= map_bit(head[1]);
            end
        end
    end

endmodule
